nmi2apb_bridge: RTL and testbench
=================================

Name: nmi2apb_bridge

Overview:
- Parametrised successor to the fixed-count memory-to-APB bridge in the peripheral wrapper.
- Converts one native memory interface (valid/ready, addr, wdata, wstrb, rdata) into an APB4 master driving SLV_NUM slaves.
- Slave address decode is parameterised; flattened prdata replaces the per-slave ports.
- Adds behaviour the old bridge lacks: decode-error and pready-timeout detection, an error response on the memory side, and an error log (count plus last faulting address).

Parameters:
- SLV_NUM, 9, number of APB slaves (1..16).
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width (multiple of 8).
- BASE_ADDR, 32'h1000_0000, APB window base address.
- BASE_MASK, 32'hFFFF_0000, window hit when (addr & BASE_MASK) == BASE_ADDR.
- DEC_LSB, 12, LSB of the slave-index field in addr.
- DEC_MSB, 15, MSB of the slave-index field in addr.
- TIMEOUT, 255, ACCESS cycles allowed before abort; 0 disables the timeout.
- ERR_RDATA, 32'hDEAD_BEEF, rdata returned on any error.

Ports:
- clk_i, in, 1, clock.
- rst_i, in, 1, synchronous active-high reset.
- mem_valid_i, in, 1, request valid; held high until ready.
- mem_addr_i, in, ADDR_WIDTH, byte address.
- mem_wdata_i, in, DATA_WIDTH, write data.
- mem_wstrb_i, in, DATA_WIDTH/8, byte strobes; 0 means read.
- mem_rdata_o, out, DATA_WIDTH, read data, valid while mem_ready_o is high.
- mem_ready_o, out, 1, one-cycle completion pulse.
- mem_err_o, out, 1, error flag qualified by mem_ready_o.
- apb_paddr_o, out, ADDR_WIDTH, APB address.
- apb_pprot_o, out, 3, constant 3'b000.
- apb_psel_o, out, SLV_NUM, one-hot slave select.
- apb_penable_o, out, 1, APB enable.
- apb_pwrite_o, out, 1, APB write.
- apb_pwdata_o, out, DATA_WIDTH, APB write data.
- apb_pstrb_o, out, DATA_WIDTH/8, APB strobes.
- apb_pready_i, in, SLV_NUM, per-slave ready.
- apb_prdata_i, in, SLV_NUM*DATA_WIDTH, slave i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- apb_pslverr_i, in, SLV_NUM, per-slave error.
- err_cnt_o, out, 16, saturating error count.
- err_addr_o, out, ADDR_WIDTH, address of the most recent error.

Behaviour:
- Interface: one clock (clk_i); reset rst_i is synchronous and active-high.
- Reset: state IDLE; every output 0; internal address/data/index/timeout registers cleared. A reset mid-transfer drops psel and penable on the next edge. No mem_ready_o is produced for the aborted request; the requester reissues it.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - When mem_valid_i is high, latch addr, wdata and wstrb; set idx = addr[DEC_MSB:DEC_LSB].
  - Window miss or idx >= SLV_NUM: go to RESP with decode error. No psel is asserted.
  - Otherwise go to SETUP.
- SETUP:
  - psel[idx]=1, penable=0.
  - paddr = latched addr; pwrite = |wstrb; pwdata = wdata.
  - pstrb = wstrb on writes, 0 on reads.
  - Always go to ACCESS after one cycle.
- ACCESS:
  - psel[idx]=1, penable=1; all APB outputs held stable.
  - If pready[idx]: capture prdata slice idx and pslverr[idx]; go to RESP.
  - Else increment the timeout counter (width $clog2(TIMEOUT+1)).
  - When the counter reaches TIMEOUT-1 with pready still low: timeout error, go to RESP.
  - If pready rises in the expiry cycle, pready wins and no timeout is flagged.
  - TIMEOUT=0: the counter is never checked.
- RESP:
  - psel=0, penable=0; mem_ready_o=1 for exactly one cycle; then go to IDLE.
  - mem_rdata_o = captured prdata on a successful read; 0 on writes; ERR_RDATA on any error.
  - mem_err_o = pslverr | decode error | timeout.
- Outside RESP: mem_ready_o=0 and mem_err_o=0; mem_rdata_o holds its last value.
- Error log: on any error in RESP, err_cnt_o increments (holds at 16'hFFFF) and err_addr_o takes the latched addr. Both change only on errors and on reset.
- Latency from the first cycle mem_valid_i is seen in IDLE to mem_ready_o:
  - Zero-wait slave: 3 cycles.
  - Each slave wait state: +1 cycle.
  - Decode error: 1 cycle.
  - Timeout: TIMEOUT+2 cycles.
- Back-to-back requests: the requester deasserts valid after sampling ready. IDLE samples on the cycle after RESP, so minimum spacing between accepted requests is 4 cycles.
- Inputs change only while idle; latched values are used throughout the transfer.
- apb_psel_o is at most one-hot at all times.
- Non-selected pready, prdata and pslverr inputs are ignored.

Test Plan:
- Read, zero-wait: read addr 32'h1000_2004, slave 2 pready=1, prdata slice2=32'hA5A5_0001 -> psel=9'b000000100 for 2 cycles (penable on the 2nd); mem_ready_o 3 cycles after valid; rdata=32'hA5A5_0001; mem_err_o=0.
- Write, 3 wait states: slave 5, wstrb=4'b0011, wdata=32'h1234_5678 -> pwrite=1; pstrb=4'b0011; APB signals stable through 4 ACCESS cycles; mem_ready_o at cycle 6; err_cnt_o unchanged.
- Decode errors:
  - addr 32'h1000_F000 (idx 15 >= 9) -> no psel; mem_ready_o after 1 cycle; mem_err_o=1; rdata=32'hDEAD_BEEF; err_cnt_o=1; err_addr_o=32'h1000_F000.
  - addr 32'h2000_0000 (window miss) -> same response; err_cnt_o=2.
- Timeout (TIMEOUT=4): slave 1 never asserts pready -> penable high exactly 4 cycles, then dropped; mem_err_o=1; rdata=ERR_RDATA.
- Timeout tie: same setup, but pready arrives in the 4th ACCESS cycle -> mem_err_o=0.
- pslverr: slave 0 returns pready=1, pslverr=1 on a read -> mem_err_o=1; rdata=ERR_RDATA; err_cnt_o increments.
- Saturation: after forced 16'hFFFF, another error -> err_cnt_o stays 16'hFFFF.
- Reset mid-ACCESS: assert rst_i for 1 cycle -> next edge psel=0, penable=0, mem_ready_o=0, err_cnt_o=0; a reissued request completes normally.

Source files
------------

// File: rtl/nmi2apb_bridge.sv
// Native memory request to APB4 master bridge for SLV_NUM slaves.
// Detects decode errors and pready timeouts, and keeps a small error log.
module nmi2apb_bridge #(
  parameter int unsigned              SLV_NUM    = 9,
  parameter int unsigned              ADDR_WIDTH = 32,
  parameter int unsigned              DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]    BASE_ADDR  = 32'h1000_0000,
  parameter logic [ADDR_WIDTH-1:0]    BASE_MASK  = 32'hFFFF_0000,
  parameter int unsigned              DEC_LSB    = 12,
  parameter int unsigned              DEC_MSB    = 15,
  parameter int unsigned              TIMEOUT    = 255,
  parameter logic [DATA_WIDTH-1:0]    ERR_RDATA  = 32'hDEAD_BEEF
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           mem_valid_i,
  input  logic [ADDR_WIDTH-1:0]          mem_addr_i,
  input  logic [DATA_WIDTH-1:0]          mem_wdata_i,
  input  logic [DATA_WIDTH/8-1:0]        mem_wstrb_i,
  output logic [DATA_WIDTH-1:0]          mem_rdata_o,
  output logic                           mem_ready_o,
  output logic                           mem_err_o,
  output logic [ADDR_WIDTH-1:0]          apb_paddr_o,
  output logic [2:0]                     apb_pprot_o,
  output logic [SLV_NUM-1:0]             apb_psel_o,
  output logic                           apb_penable_o,
  output logic                           apb_pwrite_o,
  output logic [DATA_WIDTH-1:0]          apb_pwdata_o,
  output logic [DATA_WIDTH/8-1:0]        apb_pstrb_o,
  input  logic [SLV_NUM-1:0]             apb_pready_i,
  input  logic [SLV_NUM*DATA_WIDTH-1:0]  apb_prdata_i,
  input  logic [SLV_NUM-1:0]             apb_pslverr_i,
  output logic [15:0]                    err_cnt_o,
  output logic [ADDR_WIDTH-1:0]          err_addr_o
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned IDX_W  = DEC_MSB - DEC_LSB + 1;
  localparam int unsigned TCNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [TCNT_W-1:0]       tcnt_q, tcnt_d;
  logic [SLV_NUM-1:0]      psel_q, psel_d;
  logic                    penable_q, penable_d;
  logic                    pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
  logic [STRB_W-1:0]       pstrb_q, pstrb_d;
  logic                    mem_ready_q, mem_ready_d;
  logic                    mem_err_q, mem_err_d;
  logic [DATA_WIDTH-1:0]   mem_rdata_q, mem_rdata_d;
  logic [15:0]             err_cnt_q, err_cnt_d;
  logic [ADDR_WIDTH-1:0]   err_addr_q, err_addr_d;

  logic [IDX_W-1:0]        req_idx;
  logic                    dec_err;
  logic                    sel_pready;
  logic                    sel_pslverr;
  logic [DATA_WIDTH-1:0]   sel_prdata;
  logic                    err_now;
  logic [ADDR_WIDTH-1:0]   err_now_addr;

  // Only the latched slave's response lines are ever looked at.
  always_comb begin
    sel_pready  = 1'b0;
    sel_pslverr = 1'b0;
    sel_prdata  = '0;
    for (int i = 0; i < int'(SLV_NUM); i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel_pready  = apb_pready_i[i];
        sel_pslverr = apb_pslverr_i[i];
        sel_prdata  = apb_prdata_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign req_idx = mem_addr_i[DEC_MSB:DEC_LSB];
  assign dec_err = ((mem_addr_i & BASE_MASK) != BASE_ADDR) ||
                   (32'(req_idx) >= SLV_NUM);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    idx_d        = idx_q;
    tcnt_d       = tcnt_q;
    psel_d       = psel_q;
    penable_d    = penable_q;
    pwrite_d     = pwrite_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
    pstrb_d      = pstrb_q;
    mem_ready_d  = 1'b0;
    mem_err_d    = 1'b0;
    mem_rdata_d  = mem_rdata_q;
    err_cnt_d    = err_cnt_q;
    err_addr_d   = err_addr_q;
    err_now      = 1'b0;
    err_now_addr = addr_q;

    unique case (state_q)
      IDLE: begin
        if (mem_valid_i) begin
          addr_d = mem_addr_i;
          idx_d  = req_idx;
          if (dec_err) begin
            state_d      = RESP;
            mem_ready_d  = 1'b1;
            mem_err_d    = 1'b1;
            mem_rdata_d  = ERR_RDATA;
            err_now      = 1'b1;
            err_now_addr = mem_addr_i;
          end else begin
            // Outputs are registered, so SETUP's APB values are loaded here.
            state_d   = SETUP;
            psel_d    = SLV_NUM'(1) << req_idx;
            penable_d = 1'b0;
            paddr_d   = mem_addr_i;
            pwrite_d  = |mem_wstrb_i;
            pwdata_d  = mem_wdata_i;
            pstrb_d   = (|mem_wstrb_i) ? mem_wstrb_i : '0;
          end
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
        tcnt_d    = '0;
      end
      ACCESS: begin
        if (sel_pready) begin
          state_d     = RESP;
          psel_d      = '0;
          penable_d   = 1'b0;
          mem_ready_d = 1'b1;
          mem_err_d   = sel_pslverr;
          err_now     = sel_pslverr;
          if (sel_pslverr)   mem_rdata_d = ERR_RDATA;
          else if (pwrite_q) mem_rdata_d = '0;
          else               mem_rdata_d = sel_prdata;
        end else if ((TIMEOUT != 0) && (tcnt_q == TCNT_LAST)) begin
          state_d     = RESP;
          psel_d      = '0;
          penable_d   = 1'b0;
          mem_ready_d = 1'b1;
          mem_err_d   = 1'b1;
          mem_rdata_d = ERR_RDATA;
          err_now     = 1'b1;
        end else begin
          tcnt_d = tcnt_q + TCNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (err_now) begin
      if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
      err_addr_d = err_now_addr;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      idx_q       <= '0;
      tcnt_q      <= '0;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      mem_ready_q <= 1'b0;
      mem_err_q   <= 1'b0;
      mem_rdata_q <= '0;
      err_cnt_q   <= '0;
      err_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      idx_q       <= idx_d;
      tcnt_q      <= tcnt_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      mem_ready_q <= mem_ready_d;
      mem_err_q   <= mem_err_d;
      mem_rdata_q <= mem_rdata_d;
      err_cnt_q   <= err_cnt_d;
      err_addr_q  <= err_addr_d;
    end
  end

  assign mem_rdata_o   = mem_rdata_q;
  assign mem_ready_o   = mem_ready_q;
  assign mem_err_o     = mem_err_q;
  assign apb_paddr_o   = paddr_q;
  assign apb_pprot_o   = 3'b000;
  assign apb_psel_o    = psel_q;
  assign apb_penable_o = penable_q;
  assign apb_pwrite_o  = pwrite_q;
  assign apb_pwdata_o  = pwdata_q;
  assign apb_pstrb_o   = pstrb_q;
  assign err_cnt_o     = err_cnt_q;
  assign err_addr_o    = err_addr_q;

endmodule

// File: tb/tb_nmi2apb_bridge.sv
// Directed bench for nmi2apb_bridge with a small APB slave model (TIMEOUT=4).
module tb_nmi2apb_bridge;

  localparam int SLV = 9;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SW  = DW / 8;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              mem_valid_i;
  logic [AW-1:0]     mem_addr_i;
  logic [DW-1:0]     mem_wdata_i;
  logic [SW-1:0]     mem_wstrb_i;
  logic [DW-1:0]     mem_rdata_o;
  logic              mem_ready_o;
  logic              mem_err_o;
  logic [AW-1:0]     apb_paddr_o;
  logic [2:0]        apb_pprot_o;
  logic [SLV-1:0]    apb_psel_o;
  logic              apb_penable_o;
  logic              apb_pwrite_o;
  logic [DW-1:0]     apb_pwdata_o;
  logic [SW-1:0]     apb_pstrb_o;
  logic [SLV-1:0]    apb_pready_i;
  logic [SLV*DW-1:0] apb_prdata_i;
  logic [SLV-1:0]    apb_pslverr_i;
  logic [15:0]       err_cnt_o;
  logic [AW-1:0]     err_addr_o;

  logic [SLV-1:0]    ready_mask;
  logic [SLV-1:0]    slverr_mask;
  logic [DW-1:0]     slice [SLV];
  int                wait_states;
  int                acc_cnt = 0;
  int                errors = 0;
  int                checks = 0;

  nmi2apb_bridge #(.TIMEOUT(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .mem_valid_i(mem_valid_i), .mem_addr_i(mem_addr_i),
    .mem_wdata_i(mem_wdata_i), .mem_wstrb_i(mem_wstrb_i),
    .mem_rdata_o(mem_rdata_o), .mem_ready_o(mem_ready_o), .mem_err_o(mem_err_o),
    .apb_paddr_o(apb_paddr_o), .apb_pprot_o(apb_pprot_o),
    .apb_psel_o(apb_psel_o), .apb_penable_o(apb_penable_o),
    .apb_pwrite_o(apb_pwrite_o), .apb_pwdata_o(apb_pwdata_o),
    .apb_pstrb_o(apb_pstrb_o), .apb_pready_i(apb_pready_i),
    .apb_prdata_i(apb_prdata_i), .apb_pslverr_i(apb_pslverr_i),
    .err_cnt_o(err_cnt_o), .err_addr_o(err_addr_o)
  );

  always #5 clk_i = ~clk_i;

  // Slave model: pready rises after wait_states ACCESS cycles, gated by ready_mask.
  always @(posedge clk_i) begin
    if (apb_penable_o) acc_cnt <= acc_cnt + 1;
    else               acc_cnt <= 0;
  end

  assign apb_pready_i  = (apb_penable_o && acc_cnt >= wait_states) ? ready_mask : '0;
  assign apb_pslverr_i = slverr_mask;

  for (genvar g = 0; g < SLV; g++) begin : g_prdata
    assign apb_prdata_i[g*DW +: DW] = slice[g];
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Issues one request and records what the APB side and memory side did.
  task automatic applyStimulus(input string tag, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wdata, input logic [SW-1:0] wstrb,
                               input logic [SLV-1:0] exp_sel,
                               output int lat, output int psel_cyc, output int pen_cyc,
                               output int apb_bad, output logic [DW-1:0] rdata,
                               output logic err);
    logic seen;
    seen = 1'b0; lat = 0; psel_cyc = 0; pen_cyc = 0; apb_bad = 0;
    rdata = '0; err = 1'b0;
    mem_addr_i  = addr;
    mem_wdata_i = wdata;
    mem_wstrb_i = wstrb;
    mem_valid_i = 1'b1;
    while (!seen && lat < 50) begin
      @(posedge clk_i); #1;
      lat++;
      if (apb_psel_o != '0) begin
        psel_cyc++;
        if (apb_psel_o != exp_sel || apb_paddr_o != addr ||
            apb_pwrite_o != (|wstrb) || apb_pwdata_o != wdata ||
            apb_pstrb_o != wstrb)
          apb_bad++;
      end
      if ($countones(apb_psel_o) > 1) apb_bad++;
      if (apb_penable_o) pen_cyc++;
      if (mem_ready_o) begin
        seen  = 1'b1;
        rdata = mem_rdata_o;
        err   = mem_err_o;
      end
    end
    mem_valid_i = 1'b0;
    checkOutput({tag, "_ready_seen"}, 64'(seen), 64'd1);
    @(posedge clk_i); #1;
    checkOutput({tag, "_ready_pulse"}, 64'({mem_ready_o, mem_err_o}), 64'd0);
    checkOutput({tag, "_rdata_hold"}, 64'(mem_rdata_o), 64'(rdata));
  endtask

  task automatic runCase(input string tag, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input logic [SW-1:0] wstrb,
                         input logic [SLV-1:0] exp_sel, input int exp_lat,
                         input int exp_psel, input int exp_pen,
                         input logic [DW-1:0] exp_rdata, input logic exp_err);
    int lat, pc, ec, bad;
    logic [DW-1:0] rd;
    logic er;
    applyStimulus(tag, addr, wdata, wstrb, exp_sel, lat, pc, ec, bad, rd, er);
    checkOutput({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    checkOutput({tag, "_psel_cycles"}, 64'(pc), 64'(exp_psel));
    checkOutput({tag, "_penable_cycles"}, 64'(ec), 64'(exp_pen));
    checkOutput({tag, "_apb_signals"}, 64'(bad), 64'd0);
    checkOutput({tag, "_rdata"}, 64'(rd), 64'(exp_rdata));
    checkOutput({tag, "_err"}, 64'(er), 64'(exp_err));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_i       = 1'b1;
    mem_valid_i = 1'b0;
    mem_addr_i  = '0;
    mem_wdata_i = '0;
    mem_wstrb_i = '0;
    wait_states = 0;
    ready_mask  = '1;
    slverr_mask = 9'b000001000;
    for (int i = 0; i < SLV; i++) slice[i] = 32'h5A5A_0000 + DW'(i);
    slice[2] = 32'hA5A5_0001;

    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("reset_psel", 64'(apb_psel_o), 64'd0);
    checkOutput("reset_penable", 64'(apb_penable_o), 64'd0);
    checkOutput("reset_ready_err", 64'({mem_ready_o, mem_err_o}), 64'd0);
    checkOutput("reset_rdata", 64'(mem_rdata_o), 64'd0);
    checkOutput("reset_paddr", 64'(apb_paddr_o), 64'd0);
    checkOutput("reset_err_cnt", 64'(err_cnt_o), 64'd0);
    checkOutput("reset_err_addr", 64'(err_addr_o), 64'd0);
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    runCase("rd_s2", 32'h1000_2004, 32'h0, 4'b0000, 9'b000000100,
            3, 2, 1, 32'hA5A5_0001, 1'b0);
    checkOutput("pprot", 64'(apb_pprot_o), 64'd0);

    wait_states = 3;
    runCase("wr_s5", 32'h1000_5010, 32'h1234_5678, 4'b0011, 9'b000100000,
            6, 5, 4, 32'h0, 1'b0);
    checkOutput("wr_s5_err_cnt", 64'(err_cnt_o), 64'd0);
    wait_states = 0;

    runCase("dec_idx15", 32'h1000_F000, 32'h0, 4'b0000, 9'b0,
            1, 0, 0, 32'hDEAD_BEEF, 1'b1);
    checkOutput("dec_idx15_err_cnt", 64'(err_cnt_o), 64'd1);
    checkOutput("dec_idx15_err_addr", 64'(err_addr_o), 64'h1000_F000);

    runCase("dec_miss", 32'h2000_0000, 32'h0, 4'b0000, 9'b0,
            1, 0, 0, 32'hDEAD_BEEF, 1'b1);
    checkOutput("dec_miss_err_cnt", 64'(err_cnt_o), 64'd2);
    checkOutput("dec_miss_err_addr", 64'(err_addr_o), 64'h2000_0000);

    runCase("rd_s8", 32'h1000_8000, 32'h0, 4'b0000, 9'b100000000,
            3, 2, 1, 32'h5A5A_0008, 1'b0);

    ready_mask = 9'b111111101;
    runCase("timeout_s1", 32'h1000_1008, 32'h0, 4'b0000, 9'b000000010,
            6, 5, 4, 32'hDEAD_BEEF, 1'b1);
    checkOutput("timeout_err_cnt", 64'(err_cnt_o), 64'd3);
    checkOutput("timeout_err_addr", 64'(err_addr_o), 64'h1000_1008);
    ready_mask = '1;

    wait_states = 3;
    runCase("tie_s1", 32'h1000_1000, 32'h0, 4'b0000, 9'b000000010,
            6, 5, 4, 32'h5A5A_0001, 1'b0);
    checkOutput("tie_err_cnt", 64'(err_cnt_o), 64'd3);
    wait_states = 0;

    slverr_mask = 9'b000001001;
    runCase("slverr_s0", 32'h1000_0000, 32'h0, 4'b0000, 9'b000000001,
            3, 2, 1, 32'hDEAD_BEEF, 1'b1);
    checkOutput("slverr_err_cnt", 64'(err_cnt_o), 64'd4);
    checkOutput("slverr_err_addr", 64'(err_addr_o), 64'h1000_0000);
    slverr_mask = 9'b000001000;

    force dut.err_cnt_q = 16'hFFFF;
    @(posedge clk_i); #1;
    release dut.err_cnt_q;
    @(posedge clk_i); #1;
    checkOutput("sat_preload", 64'(err_cnt_o), 64'hFFFF);
    runCase("dec_idx9", 32'h1000_9000, 32'h0, 4'b0000, 9'b0,
            1, 0, 0, 32'hDEAD_BEEF, 1'b1);
    checkOutput("sat_err_cnt", 64'(err_cnt_o), 64'hFFFF);
    checkOutput("sat_err_addr", 64'(err_addr_o), 64'h1000_9000);

    wait_states = 10;
    mem_addr_i  = 32'h1000_4000;
    mem_wdata_i = '0;
    mem_wstrb_i = '0;
    mem_valid_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    checkOutput("mid_access_penable", 64'({apb_penable_o, apb_psel_o}),
                64'({1'b1, 9'b000010000}));
    rst_i       = 1'b1;
    mem_valid_i = 1'b0;
    @(posedge clk_i); #1;
    checkOutput("rst_mid_psel", 64'(apb_psel_o), 64'd0);
    checkOutput("rst_mid_penable", 64'(apb_penable_o), 64'd0);
    checkOutput("rst_mid_ready", 64'(mem_ready_o), 64'd0);
    checkOutput("rst_mid_err_cnt", 64'(err_cnt_o), 64'd0);
    rst_i       = 1'b0;
    wait_states = 0;
    @(posedge clk_i); #1;
    runCase("reissue_s4", 32'h1000_4000, 32'h0, 4'b0000, 9'b000010000,
            3, 2, 1, 32'h5A5A_0004, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
